// File: rtl/jtcop_sdram_resp_pkg.sv
// ----------------------------------------------------------------------------
// jtcop_sdram_resp_pkg
//
// Shared definitions for the SDRAM responder:
//   - state_e     : responder FSM encoding
//   - BA_*        : bank index constants used by the game's bank multiplexers
//   - NBANK       : number of request banks
//   - bank_onehot : bank index -> one-hot strobe vector
// ----------------------------------------------------------------------------
package jtcop_sdram_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,  // waiting for a prog or bank request
      ST_RDWAIT = 2'd1,  // read issued, backing memory latency not yet elapsed
      ST_BURST  = 2'd2,  // read words are being captured into data_read
      ST_WRDONE = 2'd3   // write strobe issued, rdy goes out next
   } state_e;

   localparam logic [1:0] BA_MAIN = 2'd0;
   localparam logic [1:0] BA_SND  = 2'd1;
   localparam logic [1:0] BA_GFX  = 2'd2;
   localparam logic [1:0] BA_OBJ  = 2'd3;

   localparam int NBANK = 4;

   function automatic logic [3:0] bank_onehot(input logic [1:0] b);
      return 4'b0001 << b;
   endfunction

endpackage

// File: rtl/jtcop_sdram_rr.sv
// ----------------------------------------------------------------------------
// jtcop_sdram_rr
//
// Purely combinational 4-way round-robin arbiter. The search starts at the
// pointer and walks upward with wrap 3->0; the first requesting bank wins.
//
// Ports:
//   req_i     [3:0]  request per bank
//   ptr_i     [1:0]  bank with highest priority this cycle
//   gnt_o     [3:0]  one-hot grant (zero when nothing is requested)
//   gnt_idx_o [1:0]  index of the granted bank
//   valid_o          at least one request is present
// ----------------------------------------------------------------------------
module jtcop_sdram_rr
   import jtcop_sdram_resp_pkg::*;
(
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [3:0] gnt_o,
   output logic [1:0] gnt_idx_o,
   output logic       valid_o
);

   logic [1:0] idx;

   always_comb begin
      gnt_o     = 4'b0000;
      gnt_idx_o = 2'd0;
      valid_o   = 1'b0;
      idx       = 2'd0;
      for (int k = 0; k < NBANK; k++) begin
         // 2-bit add wraps naturally from bank 3 back to bank 0
         idx = ptr_i + 2'(k);
         if (!valid_o && req_i[idx]) begin
            valid_o   = 1'b1;
            gnt_idx_o = idx;
            gnt_o     = bank_onehot(idx);
         end
      end
   end

endmodule

// File: rtl/jtcop_sdram_resp.sv
// ----------------------------------------------------------------------------
// jtcop_sdram_resp
//
// Responder end of the four-bank SDRAM request interface plus the ROM
// download port. Requests are arbitrated, given SDRAM-like handshake timing
// and served from a generic synchronous memory with MEM_LAT cycles of read
// latency.
//
// Handshake (all strobes are registered):
//   A request level is sampled in IDLE; the ack pulse appears in the next
//   cycle (A). Address/data/mask are latched at that same edge, so mem_addr
//   and mem_we are valid in cycle A. Writes pulse rdy at A+1. Reads present
//   word i on data_read at A+MEM_LAT+1+i with dok; dst marks word 0, rdy
//   marks word BURST-1. A new request is sampled no earlier than the rdy
//   cycle, so the next ack never overlaps a running transaction.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ba0..ba3_addr  [AW-1:0]  word address per bank
//   ba_rd          [3:0]     read request levels
//   ba_wr                    write request level, bank 0 only
//   ba0_din, ba0_din_m       write data, active-low byte mask
//   ba_ack/dst/dok/rdy [3:0] per-bank handshake strobes
//   data_read      [15:0]    registered read data, shared by all banks
//   downloading              blocks bank requests (prog port still served)
//   prog_addr/ba/data/mask   download address, bank, data, mask
//   prog_we, prog_rd         download requests; we wins over rd
//   prog_ack, prog_rdy       download handshake pulses
//   mem_addr  [AW+1:0]       {bank, word address} to backing memory
//   mem_we, mem_wrmask       write strobe and active-low byte mask
//   mem_din, mem_dout        memory write / read data
// ----------------------------------------------------------------------------
module jtcop_sdram_resp
   import jtcop_sdram_resp_pkg::*;
#(
   parameter int BURST   = 2,
   parameter int MEM_LAT = 2,
   parameter int AW      = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ba0_addr,
   input  logic [AW-1:0] ba1_addr,
   input  logic [AW-1:0] ba2_addr,
   input  logic [AW-1:0] ba3_addr,
   input  logic [3:0]    ba_rd,
   input  logic          ba_wr,
   input  logic [15:0]   ba0_din,
   input  logic [1:0]    ba0_din_m,
   output logic [3:0]    ba_ack,
   output logic [3:0]    ba_dst,
   output logic [3:0]    ba_dok,
   output logic [3:0]    ba_rdy,
   output logic [15:0]   data_read,
   input  logic          downloading,
   input  logic [AW-1:0] prog_addr,
   input  logic [1:0]    prog_ba,
   input  logic [15:0]   prog_data,
   input  logic [1:0]    prog_mask,
   input  logic          prog_we,
   input  logic          prog_rd,
   output logic          prog_ack,
   output logic          prog_rdy,
   output logic [AW+1:0] mem_addr,
   output logic          mem_we,
   output logic [1:0]    mem_wrmask,
   output logic [15:0]   mem_din,
   input  logic [15:0]   mem_dout
);

   // cnt counts cycles since the ack cycle (cnt=0 in cycle A)
   localparam int            CW     = $clog2(MEM_LAT + BURST + 1);
   localparam logic [CW-1:0] LAT_C  = CW'(MEM_LAT);
   localparam logic [CW-1:0] LAST_C = CW'(MEM_LAT + BURST - 1);
   localparam logic [CW-1:0] ISS_C  = CW'(BURST - 1);

   state_e          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      bank_q, bank_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            prog_q, prog_d;      // current transaction belongs to prog port
   logic [3:0]      ack_q, ack_d;
   logic [3:0]      dst_q, dst_d;
   logic [3:0]      dok_q, dok_d;
   logic [3:0]      rdy_q, rdy_d;
   logic [15:0]     rdata_q, rdata_d;
   logic            pack_q, pack_d;
   logic            prdy_q, prdy_d;
   logic [AW+1:0]   maddr_q, maddr_d;
   logic            mwe_q, mwe_d;
   logic [1:0]      mmask_q, mmask_d;
   logic [15:0]     mdin_q, mdin_d;

   logic [3:0]      req;
   logic [3:0]      gnt;
   logic [1:0]      gnt_idx;
   logic            gnt_vld;
   logic [AW-1:0]   gnt_addr;
   logic            capture;
   logic [AW-1:0]   next_addr;

   assign req = {ba_rd[3:1], ba_rd[0] | ba_wr};

   jtcop_sdram_rr u_rr (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .valid_o   (gnt_vld)
   );

   always_comb begin
      gnt_addr = ba0_addr;
      case (gnt_idx)
         BA_MAIN: gnt_addr = ba0_addr;
         BA_SND:  gnt_addr = ba1_addr;
         BA_GFX:  gnt_addr = ba2_addr;
         BA_OBJ:  gnt_addr = ba3_addr;
         default: gnt_addr = ba0_addr;
      endcase
   end

   // Word i of a burst is on mem_dout while cnt == MEM_LAT+i
   assign capture   = (cnt_q >= LAT_C);
   // Next burst address; the AW-bit add wraps at the top of the bank
   assign next_addr = addr_q + AW'(cnt_q) + AW'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      addr_d  = addr_q;
      prog_d  = prog_q;
      rdata_d = rdata_q;
      maddr_d = maddr_q;
      mmask_d = mmask_q;
      mdin_d  = mdin_q;
      // strobes are single-cycle pulses unless re-asserted below
      ack_d   = 4'b0000;
      dst_d   = 4'b0000;
      dok_d   = 4'b0000;
      rdy_d   = 4'b0000;
      pack_d  = 1'b0;
      prdy_d  = 1'b0;
      mwe_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (prog_we || prog_rd) begin
               // download port always wins, regardless of downloading
               pack_d  = 1'b1;
               prog_d  = 1'b1;
               bank_d  = prog_ba;
               addr_d  = prog_addr;
               maddr_d = {prog_ba, prog_addr};
               cnt_d   = '0;
               if (prog_we) begin
                  mwe_d   = 1'b1;
                  mdin_d  = prog_data;
                  mmask_d = prog_mask;
                  state_d = ST_WRDONE;
               end else begin
                  state_d = ST_RDWAIT;
               end
            end else if (!downloading && gnt_vld) begin
               ack_d   = gnt;
               ptr_d   = gnt_idx + 2'd1;
               prog_d  = 1'b0;
               bank_d  = gnt_idx;
               addr_d  = gnt_addr;
               maddr_d = {gnt_idx, gnt_addr};
               cnt_d   = '0;
               // on bank 0 a pending write takes precedence over a read
               if (gnt_idx == BA_MAIN && ba_wr) begin
                  mwe_d   = 1'b1;
                  mdin_d  = ba0_din;
                  mmask_d = ba0_din_m;
                  state_d = ST_WRDONE;
               end else begin
                  state_d = ST_RDWAIT;
               end
            end
         end

         ST_WRDONE: begin
            if (prog_q) prdy_d = 1'b1;
            else        rdy_d  = bank_onehot(bank_q);
            state_d = ST_IDLE;
         end

         ST_RDWAIT, ST_BURST: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < ISS_C) begin
               maddr_d = {bank_q, next_addr};
            end
            if (capture) begin
               rdata_d = mem_dout;
               if (!prog_q) begin
                  dok_d = bank_onehot(bank_q);
                  if (cnt_q == LAT_C)  dst_d = bank_onehot(bank_q);
                  if (cnt_q == LAST_C) rdy_d = bank_onehot(bank_q);
               end else if (cnt_q == LAST_C) begin
                  prdy_d = 1'b1;
               end
            end
            if (cnt_q == LAST_C)               state_d = ST_IDLE;
            else if (cnt_q + 1'b1 >= LAT_C)    state_d = ST_BURST;
            else                               state_d = ST_RDWAIT;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
         bank_q  <= 2'd0;
         addr_q  <= '0;
         prog_q  <= 1'b0;
         ack_q   <= 4'b0000;
         dst_q   <= 4'b0000;
         dok_q   <= 4'b0000;
         rdy_q   <= 4'b0000;
         rdata_q <= 16'h0000;
         pack_q  <= 1'b0;
         prdy_q  <= 1'b0;
         maddr_q <= '0;
         mwe_q   <= 1'b0;
         mmask_q <= 2'b00;
         mdin_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         prog_q  <= prog_d;
         ack_q   <= ack_d;
         dst_q   <= dst_d;
         dok_q   <= dok_d;
         rdy_q   <= rdy_d;
         rdata_q <= rdata_d;
         pack_q  <= pack_d;
         prdy_q  <= prdy_d;
         maddr_q <= maddr_d;
         mwe_q   <= mwe_d;
         mmask_q <= mmask_d;
         mdin_q  <= mdin_d;
      end
   end

   assign ba_ack     = ack_q;
   assign ba_dst     = dst_q;
   assign ba_dok     = dok_q;
   assign ba_rdy     = rdy_q;
   assign data_read  = rdata_q;
   assign prog_ack   = pack_q;
   assign prog_rdy   = prdy_q;
   assign mem_addr   = maddr_q;
   assign mem_we     = mwe_q;
   assign mem_wrmask = mmask_q;
   assign mem_din    = mdin_q;

endmodule

// File: doc/jtcop_sdram_resp.md
Name: jtcop_sdram_resp

Overview:
- Responder end of the four-bank SDRAM request interface used by the game's bank multiplexers (ba*_addr / ba_rd / ba_wr / ba_ack / ba_dst / ba_dok / ba_rdy / data_read), plus the ROM-download prog_* port.
- Arbitrates the requests, reproduces SDRAM-style handshake timing, and serves them from a generic synchronous memory port.
- Used in simulation benches and in BRAM-backed builds without an SDRAM controller.

Parameters:
- BURST, 2, words returned per read request (32-bit slots consume both words; 8/16-bit slots use the first).
- MEM_LAT, 2, read latency of the backing memory in cycles (1..7).
- AW, 22, word address width per bank.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- ba0_addr, ba1_addr, ba2_addr, ba3_addr  in  AW each  word addresses per bank
- ba_rd  in  4  read request per bank; level, held until acked
- ba_wr  in  1  write request, bank 0 only; level, held until acked
- ba0_din  in  16  write data
- ba0_din_m  in  2  write mask, active low per byte
- ba_ack  out  4  request accepted, one-cycle pulse
- ba_dst  out  4  first data word present on data_read
- ba_dok  out  4  data_read holds a valid word for this bank
- ba_rdy  out  4  transaction finished, one-cycle pulse
- data_read  out  16  read data, shared by all banks
- downloading  in  1  download in progress; bank requests are not served
- prog_addr  in  AW  download word address
- prog_ba  in  2  download bank
- prog_data  in  16  download data
- prog_mask  in  2  download mask, active low
- prog_we  in  1  download write request
- prog_rd  in  1  download read request
- prog_ack  out  1  download request accepted, pulse
- prog_rdy  out  1  download transaction done, pulse
- mem_addr  out  AW+2  {bank, word address} to backing memory
- mem_we  out  1  backing memory write strobe
- mem_wrmask  out  2  active-low byte mask to backing memory
- mem_din  out  16  write data to backing memory
- mem_dout  in  16  read data, valid MEM_LAT cycles after mem_addr

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; round-robin pointer goes to 0. Asserting rst mid-burst abandons the transaction with no rdy pulse.
- FSM states: IDLE, RDWAIT, BURST, WRDONE.
- IDLE, prog port: if prog_we or prog_rd is high, pulse prog_ack.
  - prog_we has priority over prog_rd when both are high.
  - Write: mem_we is asserted in the ack cycle, then WRDONE.
  - Read: follows the same read path as a bank read, with prog_rdy at the end and no ba_* strobes.
- IDLE, banks: the prog port has absolute priority. Bank requests are considered only when downloading=0.
- Bank request set: req[0] = ba_rd[0] | ba_wr; req[3:1] = ba_rd[3:1].
- Grant: the first set bit of req, searched from the pointer upward with wrap 3→0. The pointer becomes grant+1 mod 4.
- Accept: pulse ba_ack[g] in the cycle after the request is sampled. Address, data and mask are latched in the ack cycle.
- Bank 0 write (ba_wr=1 at grant; ba_wr wins over ba_rd[0]):
  - mem_we=1 for one cycle in the ack cycle (call it A).
  - ba_rdy[0] pulses at A+1 (WRDONE).
  - ba_dst and ba_dok stay low.
- Read:
  - mem_addr = {g, addr+i} for i = 0..BURST-1, on consecutive cycles starting at A. The addr+i increment wraps modulo 2^AW.
  - data_read is registered. Word i appears at A+MEM_LAT+1+i with ba_dok[g]=1.
  - ba_dst[g] coincides with word 0.
  - ba_rdy[g] coincides with word BURST-1.
  - data_read holds its last value afterwards.
- Back-to-back: the next ack occurs no earlier than the cycle after the rdy cycle. There is no overlap.
- Requests dropped before ack are ignored with no error.
- downloading rising mid-transaction: the current bank transaction completes; new bank requests are then blocked.
- Only one bit of each of ba_ack, ba_dst, ba_rdy is ever set at a time.

Decomposition:
- Shared package: FSM state encoding and bank index constants (BA_MAIN=0, BA_SND=1, BA_GFX=2, BA_OBJ=3).
- One sub-module, jtcop_sdram_rr: 4-way round-robin arbiter (req, pointer → grant one-hot, valid).

Test Plan:
- Single read, bank 1, addr 0x00010, mem[1:0x10]=0x1234, mem[1:0x11]=0xABCD, MEM_LAT=2:
  - ack[1] at A; dst[1]+dok[1] with 0x1234 at A+3; dok[1]+rdy[1] with 0xABCD at A+4.
- Bank 0 write, ba0_addr=0x100000, din=0x55AA, mask=2'b01:
  - mem_we at A with mem_addr={0,0x100000} and wrmask 2'b01; rdy[0] at A+1; then reading the same address returns 0x55xx (only the upper byte is written).
- ba_rd=4'b1111 held continuously:
  - acks granted in order 0,1,2,3,0.
  - A second stream with ba_rd=4'b1010 starting with pointer=0 grants 1,3,1.
- Wrap: ba3_addr=0x3FFFFF:
  - words read from {3,0x3FFFFF} then {3,0x000000}.
- downloading=1 with prog_we and prog_rd both high and ba_rd[2] high:
  - prog_ack pulses as a write; no ba_ack[2]; after downloading falls, ba_ack[2] is issued.
- rst asserted at A+3 of a read:
  - all outputs are 0 immediately (asynchronous); no rdy; after release, a fresh request is acked with pointer=0.
